// File: rtl/registers_if.sv
// Read/write bus of the register file: two combinational read ports and one write port.
// The master drives addresses and write data; the slave (register file) returns read data.
interface registers_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] readRegister1;
    logic [ADDR_WIDTH-1:0] readRegister2;
    logic [ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  regWrite;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    // No valid/ready: reads are combinational from the addresses, and a write
    // takes effect on the rising clk edge where regWrite is high.
    modport master (
        output readRegister1, readRegister2, writeRegister, writeData, regWrite,
        input  readData1, readData2
    );

    modport slave (
        input  readRegister1, readRegister2, writeRegister, writeData, regWrite,
        output readData1, readData2
    );
endinterface

// File: rtl/registers.sv
// 32 x 32 MIPS-style register file: reg 0 reads as zero, async active-high clear.
// Optional macro REGISTERS_BYPASS_EN forwards same-cycle write data to the read ports.
module registers #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    registers_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wr_en;

    // Writes to address 0 are dropped so entry 0 stays at its reset value.
    assign wr_en = bus.regWrite && (bus.writeRegister != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.writeRegister] <= bus.writeData;
        end
    end

    always_comb begin
        bus.readData1 = regs_q[bus.readRegister1];
        bus.readData2 = regs_q[bus.readRegister2];
`ifdef REGISTERS_BYPASS_EN
        if (bus.regWrite && (bus.writeRegister == bus.readRegister1)) begin
            bus.readData1 = bus.writeData;
        end
        if (bus.regWrite && (bus.writeRegister == bus.readRegister2)) begin
            bus.readData2 = bus.writeData;
        end
`endif
        // Address 0 overrides both storage and forwarding.
        if (bus.readRegister1 == '0) begin
            bus.readData1 = '0;
        end
        if (bus.readRegister2 == '0) begin
            bus.readData2 = '0;
        end
    end
endmodule

// File: tb/tb_registers.sv
// Bench for the register file: directed writes/reads, expected read data queued by
// the driver and compared by a separate monitor process.
module tb_registers;
    logic clk;
    logic reset;

    registers_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [31:0] mdl [32];
    int          checks = 0;
    int          errors = 0;
    event        sample_ev;

    // monitor: compares read data against queued expectations
    initial begin
        string       nm;
        logic [31:0] e1;
        logic [31:0] e2;
        forever begin
            @(sample_ev);
            #1;
            while (name_q.size() > 0 && exp_q.size() >= 2) begin
                nm = name_q.pop_front();
                e1 = exp_q.pop_front();
                e2 = exp_q.pop_front();
                checks++;
                if (bus.readData1 !== e1) begin
                    errors++;
                    $display("FAIL %s port1 addr=%0d got=%h exp=%h", nm, bus.readRegister1, bus.readData1, e1);
                end
                checks++;
                if (bus.readData2 !== e2) begin
                    errors++;
                    $display("FAIL %s port2 addr=%0d got=%h exp=%h", nm, bus.readRegister2, bus.readData2, e2);
                end
            end
        end
    end

    // driver tasks
    task automatic check(input logic [4:0] a1, input logic [31:0] e1,
                         input logic [4:0] a2, input logic [31:0] e2, input string nm);
        bus.readRegister1 = a1;
        bus.readRegister2 = a2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        name_q.push_back(nm);
        -> sample_ev;
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.regWrite      = 1'b1;
        bus.writeRegister = a;
        bus.writeData     = d;
        @(negedge clk);
        bus.regWrite = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic sweep(input string nm);
        for (int a = 0; a < 32; a++) begin
            check(5'(a), mdl[a], 5'(31 - a), mdl[31 - a], nm);
        end
    endtask

    initial begin
        logic [31:0] pre;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        // reset asserted with a write pending
        reset             = 1'b1;
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd1;
        bus.writeData     = 32'hDEAD_BEEF;
        bus.readRegister1 = 5'd0;
        bus.readRegister2 = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(5'd0, 32'h0, 5'd1, 32'h0, "reset_0_1");
        check(5'd31, 32'h0, 5'd1, 32'h0, "reset_31_1");
        bus.regWrite = 1'b0;
        reset        = 1'b0;

        // fill regs 1..31 and sweep
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
        sweep("fill_sweep");

        // write to reg 0 is discarded
        @(negedge clk);
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd0;
        bus.writeData     = 32'hFFFF_FFFF;
        #1 check(5'd0, 32'h0, 5'd0, 32'h0, "wr0_before_edge");
        @(negedge clk);
        bus.regWrite = 1'b0;
        check(5'd0, 32'h0, 5'd0, 32'h0, "wr0_after_edge");
        sweep("wr0_sweep");

        // regWrite low holds reg 7
        @(negedge clk);
        bus.regWrite      = 1'b0;
        bus.writeRegister = 5'd7;
        bus.writeData     = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(5'd7, 32'h0707_0707, 5'd7, 32'h0707_0707, "no_we_hold");

        // read during write to reg 10
`ifdef REGISTERS_BYPASS_EN
        pre = 32'hA5A5_A5A5;
`else
        pre = 32'h0A0A_0A0A;
`endif
        @(negedge clk);
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd10;
        bus.writeData     = 32'hA5A5_A5A5;
        #1 check(5'd10, pre, 5'd10, pre, "rdw_before_edge");
        @(negedge clk);
        bus.regWrite = 1'b0;
        mdl[10]      = 32'hA5A5_A5A5;
        check(5'd10, 32'hA5A5_A5A5, 5'd10, 32'hA5A5_A5A5, "rdw_after_edge");

        // back-to-back writes to reg 3
        @(negedge clk);
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd3;
        bus.writeData     = 32'h1;
        @(posedge clk);
        #1 check(5'd3, 32'h1, 5'd4, 32'h0404_0404, "b2b_first");
        @(negedge clk);
        bus.writeData = 32'h2;
        @(posedge clk);
        #1 check(5'd3, 32'h2, 5'd4, 32'h0404_0404, "b2b_second");
        @(negedge clk);
        bus.regWrite = 1'b0;
        mdl[3]       = 32'h2;
        sweep("b2b_sweep");

        // reset mid-cycle with a write pending to reg 5
        wr(5'd5, 32'hDEAD_BEEF);
        check(5'd5, 32'hDEAD_BEEF, 5'd31, 32'h1F1F_1F1F, "pre_reset");
        @(negedge clk);
        bus.regWrite      = 1'b1;
        bus.writeRegister = 5'd5;
        bus.writeData     = 32'h0000_0001;
        #1 reset = 1'b1;
        #1 check(5'd5, 32'h0, 5'd31, 32'h0, "async_reset");
        @(negedge clk);
        check(5'd5, 32'h0, 5'd10, 32'h0, "reset_beats_write");
        reset        = 1'b0;
        bus.regWrite = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        sweep("post_reset_sweep");
        wr(5'd5, 32'h0000_0055);
        check(5'd5, 32'h0000_0055, 5'd6, 32'h0, "post_reset_write");

        // drain
        for (int t = 0; t < 20 && name_q.size() > 0; t++) #1;
        if (name_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", name_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
